// File: rtl/nic_irq_vector_ctrl.sv
// nic_irq_vector_ctrl: Wishbone vectored interrupt controller driving one host interrupt line.
// Optional software-trigger register enabled by `define NIC_VIC_SW_IRQ_EN.
module nic_irq_vector_ctrl #(
  parameter int g_num_irqs        = 8,
  parameter int g_emu_len_default = 1000
) (
  input  logic                  clk_sys_i,
  input  logic                  rst_n_i,
  input  logic [5:0]            wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [3:0]            wb_sel_i,
  output logic                  wb_ack_o,
  input  logic [g_num_irqs-1:0] irqs_i,
  output logic                  irq_master_o
);
  localparam int NI = g_num_irqs;
  localparam int IW = NI > 1 ? $clog2(NI) : 1;
  localparam logic [15:0] EMU_RST = 16'(g_emu_len_default);
  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_EOI, S_WAIT} state_t;
  state_t          state_q, state_d;
  logic [18:0]     ctl_q;
  logic [NI-1:0]   imr_q, swirq_q, pend;
  logic [31:0]     ivt_q [NI];
  logic [31:0]     var_q, var_d, rdat, dat_q;
  logic [15:0]     cnt_q, cnt_d;
  logic [IW-1:0]   vec_q, vec_d, low;
  logic            ack_q, irq_q, irq_d, acc, wr, ivt_hit, eoi_wr;
  logic            en, pol, emu;
  logic            unused_ok;
  assign unused_ok    = ^wb_sel_i;
  assign acc          = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr           = acc & wb_we_i;
  assign ivt_hit      = wb_adr_i[5] && int'(wb_adr_i[4:0]) < NI;
  assign eoi_wr       = wr && wb_adr_i == 6'h07;
  assign {emu, pol, en} = ctl_q[2:0];
  assign pend         = (irqs_i | swirq_q) & imr_q;
  assign wb_ack_o     = ack_q;
  assign wb_dat_o     = dat_q;
  assign irq_master_o = irq_q;
  always_comb begin
    low = '0;
    for (int i = NI - 1; i >= 0; i--) if (pend[i]) low = IW'(i);
  end
  always_comb begin
    rdat = '0;
    case (wb_adr_i)
      6'h00:   rdat = 32'(ctl_q);
      6'h01:   rdat = 32'(irqs_i | swirq_q);
      6'h04:   rdat = 32'(imr_q);
      6'h05:   rdat = var_q;
      6'h06:   rdat = 32'(swirq_q);
      default: rdat = ivt_hit ? ivt_q[wb_adr_i[IW-1:0]] : '0;
    endcase
  end
  // cnt_q times the emulated edge pulse in ASSERT and the holdoff in WAIT
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    var_d   = var_q;
    if (!en) state_d = S_IDLE;
    else case (state_q)
      S_IDLE: if (|pend) begin
        state_d = S_ASSERT;
        vec_d   = low;
        var_d   = ivt_q[low];
        cnt_d   = ctl_q[18:3] == '0 ? 16'd1 : ctl_q[18:3];
      end
      S_ASSERT: begin
        cnt_d   = cnt_q != '0 ? cnt_q - 16'd1 : cnt_q;
        state_d = eoi_wr ? S_EOI : S_ASSERT;
      end
      S_EOI: begin
        state_d = S_WAIT;
        cnt_d   = 16'd2;
      end
      default: begin
        state_d = cnt_q == '0 ? S_IDLE : S_WAIT;
        cnt_d   = cnt_q != '0 ? cnt_q - 16'd1 : cnt_q;
      end
    endcase
    irq_d = en & ((state_q == S_ASSERT && (!emu || cnt_q != '0)) ? pol : ~pol);
  end
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      ctl_q   <= {EMU_RST, 3'b000};
      imr_q   <= '0;
      var_q   <= '0;
      cnt_q   <= '0;
      vec_q   <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      irq_q   <= 1'b0;
      for (int i = 0; i < NI; i++) ivt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      var_q   <= var_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      irq_q   <= irq_d;
      ack_q   <= acc;
      dat_q   <= (acc & ~wb_we_i) ? rdat : '0;
      if (wr && wb_adr_i == 6'h00) ctl_q <= wb_dat_i[18:0];
      if (wr && wb_adr_i == 6'h02) imr_q <= imr_q | wb_dat_i[NI-1:0];
      if (wr && wb_adr_i == 6'h03) imr_q <= imr_q & ~wb_dat_i[NI-1:0];
      if (wr && ivt_hit) ivt_q[wb_adr_i[IW-1:0]] <= wb_dat_i;
    end
  end
`ifdef NIC_VIC_SW_IRQ_EN
  logic [NI-1:0] sw_clr, sw_set;
  assign sw_clr = state_q == S_EOI ? NI'(1) << vec_q : '0;
  assign sw_set = (wr && wb_adr_i == 6'h06) ? wb_dat_i[NI-1:0] : '0;
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) swirq_q <= '0;
    else          swirq_q <= (swirq_q & ~sw_clr) | sw_set;
  end
`else
  assign swirq_q = '0;
`endif
endmodule

// File: tb/tb_nic_irq_vector_ctrl.sv
// tb_nic_irq_vector_ctrl: scoreboard bench for nic_irq_vector_ctrl; read data checked on ack.
module tb_nic_irq_vector_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [5:0]  adr = '0;
  logic [31:0] wdat = '0, rdat;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, ack, irq;
  logic [7:0]  irqs = '0;
  logic        ack_prev = 1'b0;
  int          n_cmp = 0, n_err = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  nic_irq_vector_ctrl #(.g_num_irqs(8), .g_emu_len_default(1000)) dut (
    .clk_sys_i(clk), .rst_n_i(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(rdat),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(4'hF), .wb_ack_o(ack),
    .irqs_i(irqs), .irq_master_o(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ack) begin
      check("ack_one_cycle", 32'(ack_prev), 32'd0);
      if (exp_q.size() == 0) check("ack_unexpected", 32'd1, 32'd0);
      else begin
        automatic string t = tag_q.pop_front();
        automatic logic [31:0] e = exp_q.pop_front();
        if (t != "") check(t, rdat, e);
      end
    end
    ack_prev <= ack;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic access(input logic w, input logic [5:0] a, input logic [31:0] d,
                        input string tag, input logic [31:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    adr = a; wdat = d; we = w; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick(1);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    access(1'b1, a, d, "", '0);
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] e, input string tag);
    access(1'b0, a, '0, tag, e);
  endtask

  task automatic wait_irq(input logic lvl, input int max, input string tag);
    for (int i = 0; i < max && irq !== lvl; i++) tick(1);
    check(tag, 32'(irq), 32'(lvl));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    check("rst_irq", 32'(irq), 32'd0);
    rd(6'h00, 32'h0000_1F40, "rst_ctl");
    rd(6'h04, 32'h0, "rst_imr");
    rd(6'h05, 32'h0, "rst_var");
    // software trigger
    wr(6'h20, 32'hCAFE_0000);
    wr(6'h02, 32'h1);
    wr(6'h00, 32'h3);
    wr(6'h06, 32'h1);
`ifdef NIC_VIC_SW_IRQ_EN
    wait_irq(1'b1, 3, "swir_assert");
    rd(6'h05, 32'hCAFE_0000, "swir_var");
    rd(6'h01, 32'h1, "swir_risr");
    wr(6'h07, 32'h0);
    check("swir_eoi_drop", 32'(irq), 32'd0);
    rd(6'h01, 32'h0, "swir_risr_clr");
    tick(8);
    check("swir_no_reassert", 32'(irq), 32'd0);
`else
    tick(3);
    check("swir_absent_irq", 32'(irq), 32'd0);
    rd(6'h06, 32'h0, "swir_absent_rd");
    rd(6'h01, 32'h0, "swir_absent_risr");
`endif
    // priority
    wr(6'h22, 32'h2222_2222);
    wr(6'h23, 32'h3333_3333);
    wr(6'h02, 32'hFF);
    irqs = 8'h0C;
    wait_irq(1'b1, 4, "prio_assert");
    rd(6'h05, 32'h2222_2222, "prio_var2");
    irqs = 8'h08;
    wr(6'h07, 32'h0);
    check("prio_eoi_drop", 32'(irq), 32'd0);
    wait_irq(1'b1, 10, "prio_reassert");
    rd(6'h05, 32'h3333_3333, "prio_var3");
    irqs = 8'h00;
    wr(6'h07, 32'h0);
    tick(6);
    check("prio_idle", 32'(irq), 32'd0);
    // polarity low
    wr(6'h00, 32'h1);
    check("pol0_idle_high", 32'(irq), 32'd1);
    irqs = 8'h01;
    wait_irq(1'b0, 4, "pol0_active_low");
    rd(6'h05, 32'hCAFE_0000, "pol0_var");
    irqs = 8'h00;
    wr(6'h07, 32'h0);
    wait_irq(1'b1, 8, "pol0_back_idle");
    // masking
    wr(6'h00, 32'h3);
    wr(6'h03, 32'h1);
    irqs = 8'h01;
    tick(6);
    check("masked_no_service", 32'(irq), 32'd0);
    rd(6'h04, 32'hFE, "imr_after_idr");
    irqs = 8'h00;
    // disable mid-ASSERT keeps VAR
    wr(6'h21, 32'h1111_0000);
    irqs = 8'h02;
    wait_irq(1'b1, 4, "dis_assert");
    wr(6'h00, 32'h0);
    check("dis_drop", 32'(irq), 32'd0);
    irqs = 8'h00;
    rd(6'h05, 32'h1111_0000, "dis_var_kept");
    // edge emulation, EMU_LEN=5
    wr(6'h00, 32'h7 | (32'd5 << 3));
    irqs = 8'h02;
    tick(1);
    irqs = 8'h00;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (irq) cnt++;
      tick(1);
    end
    check("emu_high_cycles", 32'(cnt), 32'd5);
    rd(6'h05, 32'h1111_0000, "emu_var_valid");
    wr(6'h07, 32'h0);
    tick(6);
    check("emu_after_eoi", 32'(irq), 32'd0);
    // level re-trigger
    wr(6'h00, 32'h3);
    wr(6'h02, 32'h1);
    irqs = 8'h01;
    wait_irq(1'b1, 4, "retrig_assert");
    wr(6'h07, 32'h0);
    cnt = 0;
    for (int i = 0; i < 20 && !irq; i++) begin
      cnt++;
      tick(1);
    end
    check("retrig_low_ge4", 32'(cnt >= 4), 32'd1);
    check("retrig_reassert", 32'(irq), 32'd1);
    // async reset mid-ASSERT
    #2 rst_n = 1'b0;
    #1 check("async_rst_drop", 32'(irq), 32'd0);
    irqs = 8'h00;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    rd(6'h00, 32'h0000_1F40, "rst2_ctl");
    rd(6'h04, 32'h0, "rst2_imr");
    rd(6'h05, 32'h0, "rst2_var");
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 10) begin
      cnt++;
      tick(1);
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
